pac_motion: RTL and testbench

- Pacman movement controller; sits directly upstream of the Pacman sprite lookup.
- Turns player buttons and a periodic move tick into a tile position plus a 4-bit one-hot sprite direction code.
- Checks each candidate tile against the maze map through a request/acknowledge wall-query port before moving.
- The renderer uses tile_x/tile_y to place the sprite and forwards direction unchanged to the sprite lookup.

---
 rtl/pac_motion.sv | 237 +++++++++++++++++++++++
 tb/tb_pac_motion.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pac_motion.sv
// ---------------------------------------------------------------------------
// pac_motion : Pacman movement controller.
//
// Turns player buttons and a periodic move tick into a tile position and a
// one-hot sprite direction code. Every candidate tile is checked against the
// maze map through a registered request/acknowledge wall-query port.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   move_tick         : one-cycle pulse requesting one step attempt
//   btn[3:0]          : buttons {L,U,R,D}
//   wall_req/qx/qy    : wall query valid and queried tile (registered)
//   wall_ack/hit      : query answered / queried tile is a wall
//   tile_x/tile_y     : current tile
//   heading           : travel direction, one-hot L=1000 U=0100 R=0010 D=0001
//   direction         : heading while mouth open, 0000 while mouth closed
//   moved             : pulse in the cycle a new tile first appears
// ---------------------------------------------------------------------------
module pac_motion #(
    parameter int MAP_W    = 28,
    parameter int MAP_H    = 31,
    parameter int START_X  = 13,
    parameter int START_Y  = 23,
    parameter int ANIM_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       move_tick,
    input  logic [3:0] btn,
    output logic       wall_req,
    output logic [4:0] wall_qx,
    output logic [4:0] wall_qy,
    input  logic       wall_ack,
    input  logic       wall_hit,
    output logic [4:0] tile_x,
    output logic [4:0] tile_y,
    output logic [3:0] heading,
    output logic [3:0] direction,
    output logic       moved
);

    typedef enum logic [1:0] {IDLE, Q_WANT, Q_HEAD, BLOCKED} state_e;

    localparam logic [3:0] DIR_L     = 4'b1000;
    localparam logic [3:0] DIR_U     = 4'b0100;
    localparam logic [3:0] DIR_R     = 4'b0010;
    localparam logic [3:0] DIR_D     = 4'b0001;
    localparam logic [4:0] X_MAX     = 5'(MAP_W - 1);
    localparam logic [4:0] Y_MAX     = 5'(MAP_H - 1);
    localparam logic [3:0] ANIM_LAST = 4'(ANIM_DIV - 1);

    // Returns {off_map, x, y}; x wraps through the tunnel, y never wraps.
    function automatic logic [10:0] next_tile(input logic [3:0] dir,
                                              input logic [4:0] x,
                                              input logic [4:0] y);
        logic [10:0] r;
        case (dir)
            DIR_L:   r = {1'b0, (x == 5'd0) ? X_MAX : x - 5'd1, y};
            DIR_R:   r = {1'b0, (x == X_MAX) ? 5'd0 : x + 5'd1, y};
            DIR_U:   r = (y == 5'd0)  ? {1'b1, x, y} : {1'b0, x, y - 5'd1};
            DIR_D:   r = (y == Y_MAX) ? {1'b1, x, y} : {1'b0, x, y + 5'd1};
            default: r = {1'b1, x, y};
        endcase
        return r;
    endfunction

    state_e      state_q, state_d;
    logic [3:0]  desired_q, desired_d;
    logic [3:0]  heading_q, heading_d;
    logic [3:0]  qdir_q, qdir_d;        // direction of the pending Q_WANT target
    logic [4:0]  tile_x_q, tile_x_d;
    logic [4:0]  tile_y_q, tile_y_d;
    logic [4:0]  qx_q, qx_d;
    logic [4:0]  qy_q, qy_d;
    logic        off_q, off_d;          // target is off the map: implicit wall
    logic        req_q, req_d;
    logic        mouth_q, mouth_d;      // 1 = mouth open
    logic [3:0]  anim_q, anim_d;
    logic [3:0]  dir_q, dir_d;
    logic        moved_q, moved_d;
    logic [10:0] nt_s;
    logic        answered_s;
    logic        hit_s;
    logic        step_ok_s;

    // Next-state logic for the query FSM, position, heading and animation.
    always_comb begin
        state_d    = state_q;
        desired_d  = desired_q;
        heading_d  = heading_q;
        qdir_d     = qdir_q;
        tile_x_d   = tile_x_q;
        tile_y_d   = tile_y_q;
        qx_d       = qx_q;
        qy_d       = qy_q;
        off_d      = off_q;
        req_d      = req_q;
        mouth_d    = mouth_q;
        anim_d     = anim_q;
        moved_d    = 1'b0;
        nt_s       = 11'd0;
        step_ok_s  = 1'b0;
        // An off-map target is answered immediately as a wall, no query issued.
        answered_s = req_q ? wall_ack : off_q;
        hit_s      = req_q ? wall_hit : 1'b1;

        if (btn[3])      desired_d = DIR_L;
        else if (btn[2]) desired_d = DIR_U;
        else if (btn[1]) desired_d = DIR_R;
        else if (btn[0]) desired_d = DIR_D;
        else             desired_d = desired_q;

        case (state_q)
            IDLE: begin
                if (move_tick) begin
                    nt_s   = next_tile(desired_d, tile_x_q, tile_y_q);
                    qdir_d = desired_d;
                    off_d  = nt_s[10];
                    qx_d   = nt_s[9:5];
                    qy_d   = nt_s[4:0];
                    req_d  = ~nt_s[10];
                    state_d = Q_WANT;
                end else begin
                    state_d = IDLE;
                end
            end
            Q_WANT: begin
                if (answered_s) begin
                    req_d = 1'b0;
                    if (!hit_s) begin
                        heading_d = qdir_q;
                        tile_x_d  = qx_q;
                        tile_y_d  = qy_q;
                        step_ok_s = 1'b1;
                        state_d   = IDLE;
                    end else if (qdir_q == heading_q) begin
                        state_d = BLOCKED;
                    end else begin
                        // Fallback target; its query starts one cycle later.
                        nt_s    = next_tile(heading_q, tile_x_q, tile_y_q);
                        off_d   = nt_s[10];
                        qx_d    = nt_s[9:5];
                        qy_d    = nt_s[4:0];
                        state_d = Q_HEAD;
                    end
                end else begin
                    state_d = Q_WANT;
                end
            end
            Q_HEAD: begin
                if (!req_q && !off_q) begin
                    req_d = 1'b1;
                end else if (answered_s) begin
                    req_d = 1'b0;
                    if (!hit_s) begin
                        tile_x_d  = qx_q;
                        tile_y_d  = qy_q;
                        step_ok_s = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        state_d = BLOCKED;
                    end
                end else begin
                    state_d = Q_HEAD;
                end
            end
            BLOCKED: begin
                mouth_d = 1'b1;
                anim_d  = 4'd0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase

        if (step_ok_s) begin
            moved_d = 1'b1;
            if (anim_q == ANIM_LAST) begin
                mouth_d = ~mouth_q;
                anim_d  = 4'd0;
            end else begin
                anim_d = anim_q + 4'd1;
            end
        end else begin
            moved_d = 1'b0;
        end

        dir_d = mouth_d ? heading_d : 4'b0000;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            desired_q <= DIR_L;
            heading_q <= DIR_L;
            qdir_q    <= DIR_L;
            tile_x_q  <= 5'(START_X);
            tile_y_q  <= 5'(START_Y);
            qx_q      <= 5'd0;
            qy_q      <= 5'd0;
            off_q     <= 1'b0;
            req_q     <= 1'b0;
            mouth_q   <= 1'b0;
            anim_q    <= 4'd0;
            dir_q     <= 4'b0000;
            moved_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            desired_q <= desired_d;
            heading_q <= heading_d;
            qdir_q    <= qdir_d;
            tile_x_q  <= tile_x_d;
            tile_y_q  <= tile_y_d;
            qx_q      <= qx_d;
            qy_q      <= qy_d;
            off_q     <= off_d;
            req_q     <= req_d;
            mouth_q   <= mouth_d;
            anim_q    <= anim_d;
            dir_q     <= dir_d;
            moved_q   <= moved_d;
        end
    end

    assign wall_req  = req_q;
    assign wall_qx   = qx_q;
    assign wall_qy   = qy_q;
    assign tile_x    = tile_x_q;
    assign tile_y    = tile_y_q;
    assign heading   = heading_q;
    assign direction = dir_q;
    assign moved     = moved_q;

endmodule

// File: tb/tb_pac_motion.sv
// Directed bench for pac_motion; the bench answers every wall query itself.
module tb_pac_motion;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       move_tick = 1'b0;
    logic [3:0] btn = 4'b0000;
    logic       wall_req;
    logic [4:0] wall_qx;
    logic [4:0] wall_qy;
    logic       wall_ack = 1'b0;
    logic       wall_hit = 1'b0;
    logic [4:0] tile_x;
    logic [4:0] tile_y;
    logic [3:0] heading;
    logic [3:0] direction;
    logic       moved;

    int n_cmp = 0;
    int n_err = 0;
    int mcount;

    pac_motion dut (
        .clk(clk), .rst(rst), .move_tick(move_tick), .btn(btn),
        .wall_req(wall_req), .wall_qx(wall_qx), .wall_qy(wall_qy),
        .wall_ack(wall_ack), .wall_hit(wall_hit),
        .tile_x(tile_x), .tile_y(tile_y), .heading(heading),
        .direction(direction), .moved(moved)
    );

    always #5 clk = ~clk;

    task automatic step_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step_cycle();
        step_cycle();
        rst = 1'b0;
    endtask

    task automatic tick();
        move_tick = 1'b1;
        step_cycle();
        move_tick = 1'b0;
    endtask

    // Wait (bounded) for a query, then answer it.
    task automatic query(input logic hit);
        int k = 0;
        while (!wall_req && k < 20) begin
            step_cycle();
            k++;
        end
        chk("req_seen", 32'(wall_req), 32'd1);
        wall_ack = 1'b1;
        wall_hit = hit;
        step_cycle();
        wall_ack = 1'b0;
        wall_hit = 1'b0;
    endtask

    task automatic walk(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            query(1'b0);
            chk("walk_moved", 32'(moved), 32'd1);
            step_cycle();
        end
    endtask

    initial begin
        // Reset state
        do_reset();
        step_cycle();
        step_cycle();
        chk("rst_x", 32'(tile_x), 32'd13);
        chk("rst_y", 32'(tile_y), 32'd23);
        chk("rst_head", 32'(heading), 32'h8);
        chk("rst_dir", 32'(direction), 32'h0);
        chk("rst_req", 32'(wall_req), 32'd0);
        chk("rst_moved", 32'(moved), 32'd0);
        chk("rst_qx", 32'(wall_qx), 32'd0);

        // Step right with a stalled ack
        btn = 4'b0010;
        step_cycle();
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("r_req", 32'(wall_req), 32'd1);
            chk("r_qx", 32'(wall_qx), 32'd14);
            chk("r_qy", 32'(wall_qy), 32'd23);
            step_cycle();
        end
        chk("r_moved_before", 32'(moved), 32'd0);
        wall_ack = 1'b1;
        step_cycle();
        wall_ack = 1'b0;
        chk("r_x", 32'(tile_x), 32'd14);
        chk("r_y", 32'(tile_y), 32'd23);
        chk("r_head", 32'(heading), 32'h2);
        chk("r_moved", 32'(moved), 32'd1);
        chk("r_dir1", 32'(direction), 32'h0);
        chk("r_req_drop", 32'(wall_req), 32'd0);
        step_cycle();
        chk("r_moved_pulse", 32'(moved), 32'd0);
        btn = 4'b0000;
        walk(1);
        chk("r_x2", 32'(tile_x), 32'd15);
        chk("r_dir2", 32'(direction), 32'h2);

        // Wanted direction hits, fallback to heading succeeds
        do_reset();
        btn = 4'b0110;   // U beats R
        step_cycle();
        btn = 4'b0000;
        tick();
        chk("fb_qx1", 32'(wall_qx), 32'd13);
        chk("fb_qy1", 32'(wall_qy), 32'd22);
        query(1'b1);
        chk("fb_req_gap", 32'(wall_req), 32'd0);
        step_cycle();
        chk("fb_req2", 32'(wall_req), 32'd1);
        chk("fb_qx2", 32'(wall_qx), 32'd12);
        chk("fb_qy2", 32'(wall_qy), 32'd23);
        query(1'b0);
        chk("fb_x", 32'(tile_x), 32'd12);
        chk("fb_y", 32'(tile_y), 32'd23);
        chk("fb_head", 32'(heading), 32'h8);
        chk("fb_moved", 32'(moved), 32'd1);

        // Both queries hit: blocked, mouth forced open
        do_reset();
        btn = 4'b0100;
        step_cycle();
        btn = 4'b0000;
        tick();
        query(1'b1);
        query(1'b1);
        chk("bl_moved", 32'(moved), 32'd0);
        step_cycle();
        chk("bl_x", 32'(tile_x), 32'd13);
        chk("bl_y", 32'(tile_y), 32'd23);
        chk("bl_dir", 32'(direction), 32'h8);
        chk("bl_req", 32'(wall_req), 32'd0);
        tick();
        chk("bl_idle_req", 32'(wall_req), 32'd1);
        chk("bl_idle_qy", 32'(wall_qy), 32'd22);

        // Tunnel wrap and top edge
        do_reset();
        walk(13);
        chk("tn_x0", 32'(tile_x), 32'd0);
        tick();
        chk("tn_qx", 32'(wall_qx), 32'd27);
        query(1'b0);
        chk("tn_x27", 32'(tile_x), 32'd27);
        step_cycle();
        btn = 4'b0100;
        step_cycle();
        btn = 4'b0000;
        walk(23);
        chk("tn_y0", 32'(tile_y), 32'd0);
        btn = 4'b1000;
        step_cycle();
        btn = 4'b0000;
        walk(1);
        chk("tn_x26", 32'(tile_x), 32'd26);
        btn = 4'b0100;
        step_cycle();
        btn = 4'b0000;
        tick();
        chk("edge_noreq1", 32'(wall_req), 32'd0);
        step_cycle();
        chk("edge_noreq2", 32'(wall_req), 32'd0);
        step_cycle();
        chk("edge_req", 32'(wall_req), 32'd1);
        chk("edge_qx", 32'(wall_qx), 32'd25);
        chk("edge_qy", 32'(wall_qy), 32'd0);
        query(1'b0);
        chk("edge_x", 32'(tile_x), 32'd25);
        chk("edge_y", 32'(tile_y), 32'd0);
        chk("edge_head", 32'(heading), 32'h8);

        // Tick during a pending query is dropped
        do_reset();
        tick();
        step_cycle();
        tick();
        wall_ack = 1'b1;
        step_cycle();
        wall_ack = 1'b0;
        mcount = 0;
        for (int i = 0; i < 6; i++) begin
            if (moved) mcount++;
            step_cycle();
        end
        chk("drop_moved_cnt", 32'(mcount), 32'd1);
        chk("drop_x", 32'(tile_x), 32'd12);
        chk("drop_req", 32'(wall_req), 32'd0);

        // Reset mid-query, late ack ignored
        tick();
        chk("mr_req_hi", 32'(wall_req), 32'd1);
        rst = 1'b1;
        step_cycle();
        rst = 1'b0;
        chk("mr_req", 32'(wall_req), 32'd0);
        chk("mr_x", 32'(tile_x), 32'd13);
        chk("mr_y", 32'(tile_y), 32'd23);
        chk("mr_head", 32'(heading), 32'h8);
        wall_ack = 1'b1;
        step_cycle();
        wall_ack = 1'b0;
        step_cycle();
        chk("mr_ack_x", 32'(tile_x), 32'd13);
        chk("mr_ack_moved", 32'(moved), 32'd0);
        chk("mr_ack_req", 32'(wall_req), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
